aes_mix_addkey: RTL and testbench

AES_MIX_ADDKEY -- requirements
Module: aes_mix_addkey

---
 rtl/aes_mix_addkey.sv | 114 +++++++++++
 tb/tb_aes_mix_addkey.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_addkey.sv
// AES round tail: MixColumns (skipped on the final round) followed by AddRoundKey.
// COLS_PER_CYCLE columns are processed per clock over a captured state.
module aes_mix_addkey #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_final,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A step of 4 wraps the 2-bit counter to 0, which is what we want.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_cnt;
    logic [127:0] r_din;
    logic [127:0] r_key;
    logic         r_final;
    logic [127:0] r_result;
    logic [127:0] w_result_nxt;
    logic         w_accept;
    logic         w_last;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic bypass);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        if (bypass) begin
            return col;
        end
        return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_state = r_result;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (int'(r_cnt) + COLS_PER_CYCLE >= 4);

    always_comb begin
        w_result_nxt = r_result;
        for (int c = 0; c < 4; c++) begin
            if (c >= int'(r_cnt) && c < int'(r_cnt) + COLS_PER_CYCLE) begin
                w_result_nxt[127-32*c -: 32] = mix_col(r_din[127-32*c -: 32], r_final)
                                               ^ r_key[127-32*c -: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = BUSY;
            BUSY:    if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_din    <= '0;
            r_key    <= '0;
            r_final  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_din   <= in_state;
            r_key   <= in_key;
            r_final <= in_final;
        end else if (r_state == BUSY) begin
            r_result <= w_result_nxt;
            r_cnt    <= r_cnt + CNT_STEP;
        end
    end

endmodule

// File: tb/tb_aes_mix_addkey.sv
// Bench for aes_mix_addkey: one instance per legal COLS_PER_CYCLE, driven by
// directed and random transactions and compared against a GF(2^8) matrix model.
module tb_aes_mix_addkey;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic [127:0] in_key    [3];
    logic         in_final  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];

    logic [127:0] exp_val  [3];
    logic         exp_pend [3];
    logic         seen     [3];
    int           acc_cyc  [3];
    int           cyc;
    int           n_vec;
    int           n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_addkey #(.COLS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_key    (in_key[g]),
            .in_final  (in_final[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpc(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    // Generic GF(2^8) multiply: carry-less product then reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic f);
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        coef = '{8'd2, 8'd3, 8'd1, 8'd1};
        res  = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = 8'(s >> (120 - 32*c - 8*r));
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    if (f) acc = acc ^ ((j == r) ? a[j] : 8'h00);
                    else   acc = acc ^ gmul(coef[(j - r + 4) % 4], a[j]);
                end
                acc = acc ^ 8'(k >> (120 - 32*c - 8*r));
                res = res | (128'(acc) << (120 - 32*c - 8*r));
            end
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    // Output compare: every cycle a DUT presents a result.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n && out_valid[d]) begin
                chk($sformatf("expected_pending[%0d]", d), 128'(exp_pend[d]), 128'd1);
                chk($sformatf("out_state[%0d]", d), out_state[d], exp_val[d]);
                chk($sformatf("in_ready_in_done[%0d]", d), 128'(in_ready[d]), 128'd0);
                if (!seen[d]) begin
                    seen[d] = 1'b1;
                    chk($sformatf("latency[%0d]", d), 128'(cyc - acc_cyc[d]), 128'(4 / cpc(d)));
                end
            end
        end
    end

    task automatic start_txn(input int d, input logic [127:0] s, input logic [127:0] k,
                             input logic f, input logic [127:0] want);
        int t;
        @(negedge clk);
        t = 0;
        while (!in_ready[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[d]) chk($sformatf("ready_wait[%0d]", d), 128'd0, 128'd1);
        in_valid[d]  = 1'b1;
        in_state[d]  = s;
        in_key[d]    = k;
        in_final[d]  = f;
        out_ready[d] = 1'b0;
        @(posedge clk);
        #1;
        exp_val[d]  = want;
        exp_pend[d] = 1'b1;
        acc_cyc[d]  = cyc;
        seen[d]     = 1'b0;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_key[d]   = {$urandom, $urandom, $urandom, $urandom};
        in_final[d] = 1'($urandom_range(0, 1));
        in_valid[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input int d, input logic [127:0] s, input logic [127:0] k,
                           input logic f, input logic [127:0] want, input int bp);
        int t;
        start_txn(d, s, k, f, want);
        t = 0;
        while (!out_valid[d] && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid[d]) begin
            chk($sformatf("out_valid_wait[%0d]", d), 128'd0, 128'd1);
        end else begin
            for (int i = 0; i < bp; i++) begin
                in_valid[d] = 1'b1;
                in_state[d] = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                #1;
            end
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        exp_pend[d]  = 1'b0;
    endtask

    initial begin
        logic [127:0] s, k, col_in, col_out, fs, fk, fo;
        logic         f;
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            in_key[d]    = '0;
            in_final[d]  = 1'b0;
            out_ready[d] = 1'b0;
            exp_val[d]   = '0;
            exp_pend[d]  = 1'b0;
            seen[d]      = 1'b0;
            acc_cyc[d]   = 0;
        end
        col_in  = {32'hd4bf5d30, 96'h0};
        col_out = {32'h046681e5, 96'h0};
        fs      = 128'h00112233445566778899aabbccddeeff;
        fk      = 128'h000102030405060708090a0b0c0d0e0f;
        fo      = 128'h00102030405060708090a0b0c0d0e0f0;

        chk("model_column", model(col_in, 128'h0, 1'b0), col_out);
        chk("model_c6", model({4{32'hc6c6c6c6}}, 128'h0, 1'b0), {4{32'hc6c6c6c6}});
        chk("model_db", model({4{32'hdb135345}}, 128'h0, 1'b0), {4{32'h8e4da1bc}});
        chk("model_final", model(fs, fk, 1'b1), fo);

        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("reset_out_state[%0d]", d), out_state[d], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("ready_after_reset[%0d]", d), 128'(in_ready[d]), 128'd1);

        for (int d = 0; d < 3; d++) begin
            run_txn(d, col_in, 128'h0, 1'b0, col_out, 0);
            run_txn(d, {4{32'hc6c6c6c6}}, 128'h0, 1'b0, {4{32'hc6c6c6c6}}, 1);
            run_txn(d, {4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}}, 0);
            run_txn(d, fs, fk, 1'b1, fo, 2);
            run_txn(d, fs, fk, 1'b0, model(fs, fk, 1'b0), 10);
        end

        // Reset in the middle of a transaction on the one-column instance.
        start_txn(0, fs, fk, 1'b0, model(fs, fk, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_pend[0] = 1'b0;
        in_valid[0] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_reset_out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("async_reset_out_state[%0d]", d), out_state[d], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_after_mid_reset", 128'(in_ready[0]), 128'd1);
        repeat (6) @(negedge clk);
        run_txn(0, col_in, fk, 1'b0, model(col_in, fk, 1'b0), 0);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 1000; n++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                k = {$urandom, $urandom, $urandom, $urandom};
                f = ($urandom_range(0, 3) == 0);
                run_txn(d, s, k, f, model(s, k, f), $urandom_range(0, 2));
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
